fpu_issue_ctrl: RTL and testbench
=================================

Name: fpu_issue_ctrl

Overview:
- Initiator side of the FP register-file/FPU link.
- Accepts one decoded FP instruction per valid/ready handshake from the core decoder.
- Drives register selects, operation code and rounding mode, then waits for `f_ready` from the cycle counter.
- Sequences FP loads and stores against a simple memory req/ack port, and issues exactly one register-file write per arithmetic op or load.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles in EXEC waiting for `f_ready` before abort.
- CNT_W, 5: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- n_rst  in  1  synchronous active-low reset
- instr_valid  in  1  decoded FP instruction present
- instr_ready  out  1  controller can accept (IDLE only)
- instr_funct7  in  7  FPU operation select
- instr_rs1  in  5  source register 1
- instr_rs2  in  5  source register 2 (store data source for FSW)
- instr_rd  in  5  destination register
- instr_rm  in  3  instruction rounding field; 3'b111 = dynamic
- instr_load  in  1  instruction is FLW
- instr_store  in  1  instruction is FSW
- csr_frm  in  3  fcsr rounding mode, used when instr_rm = 3'b111
- FPU_out  in  32  FPU result
- flags  in  5  FPU exception flags {NV,DZ,OF,UF,NX}
- f_ready  in  1  FPU result valid (single-cycle pulse)
- mem_rdata  in  32  load data
- mem_ack  in  1  memory completes request
- mem_req  out  1  memory request
- f_rs1  out  5  register select 1
- f_rs2  out  5  register select 2
- f_rd  out  5  write register
- funct_7  out  7  FPU operation
- frm  out  3  resolved rounding mode
- f_LW  out  1  write-back source is load data
- f_SW  out  1  store in progress
- f_w_data  out  32  write-back data
- f_wen  out  1  register-file write strobe, one cycle
- f_flags  out  5  flags to accrue into fcsr
- flags_we  out  1  flag accrual strobe, one cycle
- err  out  1  one-cycle pulse: illegal instruction or timeout

Behaviour:
- **Reset.** All registers update on the posedge of `clk`. When `n_rst` = 0 at a posedge, the state goes to IDLE and all outputs go to 0, except `instr_ready` = 1. Reset in any state aborts that operation; no write, no err.
- **States:** IDLE, EXEC, LOAD, STORE, WB.
- **IDLE → next state.** The instruction is accepted on `instr_valid && instr_ready`, and all `instr_*` fields are latched. Next state:
  - both `instr_load` and `instr_store` = 1 → IDLE, with `err` = 1 the following cycle.
  - `instr_load` → LOAD.
  - `instr_store` → STORE.
  - otherwise resolve rounding: `frm` = `csr_frm` if `instr_rm` = 111, else `instr_rm`.
    - resolved `frm` is 101 or 110 → IDLE, with `err` pulse.
    - else → EXEC.
- **EXEC.**
  - `f_rs1`, `f_rs2`, `funct_7` and `frm` are held from the latched values.
  - The counter clears on entry and increments each cycle.
  - On `f_ready`: latch `FPU_out` → `f_w_data` and `flags` → `f_flags`, go to WB.
  - If the counter reaches TIMEOUT_CYCLES-1 without `f_ready`: `err` pulse, go to IDLE, no write.
  - If `f_ready` and timeout coincide, `f_ready` wins.
- **LOAD.**
  - `mem_req` = 1 until `mem_ack`.
  - On `mem_ack`: latch `mem_rdata` → `f_w_data`, go to WB with `f_LW` = 1.
  - No timeout applies.
- **STORE.**
  - `f_rs2` = latched rs2, `f_SW` = 1, `mem_req` = 1 until `mem_ack`.
  - On `mem_ack`: go to IDLE. No write, no flags.
- **WB** (exactly one cycle).
  - `f_rd` = latched rd, `f_wen` = 1.
  - `flags_we` = 1 only for arithmetic ops; `f_LW` = 1 only for loads.
  - Next state is IDLE; `instr_ready` rises in the following cycle.
  - Issue-to-IDLE latency for an arithmetic op is (FPU cycles) + 2.
- **Ignored inputs.** `f_ready` outside EXEC and `mem_ack` outside LOAD/STORE are ignored. `instr_*` values are don't-care when `instr_ready` = 0.
- **Held outputs.** `f_rs1`, `f_rs2` and `f_rd` keep their last latched values between operations; they are 0 after reset.

Decomposition:
- Shared package `fpu_types_pkg`:
  - the state enum;
  - rounding-mode constants: RNE = 000, RTZ = 001, RDN = 010, RUP = 011, RMM = 100, DYN = 111;
  - the flag bit-index constants NV = 4 down to NX = 0.
- Sub-module `fpu_rm_resolve`: combinational rounding-mode select plus legality check, reused by the decoder.

Test Plan:
1. **Dynamic rounding, 3-cycle op.** Stimulus: funct7 = 7'h00, rs1 = 1, rs2 = 2, rd = 3, rm = 111, csr_frm = 001; `f_ready` 3 cycles after accept, with FPU_out = 32'h40400000 and flags = 5'b00001. Required: `frm` = 001 through EXEC; WB has `f_rd` = 3, `f_w_data` = 32'h40400000, `f_wen` = 1, `flags_we` = 1, `f_flags` = 00001; `instr_ready` returns 5 cycles after accept.
2. **Load.** Stimulus: instr_load, rd = 7; `mem_ack` after 2 wait cycles with mem_rdata = 32'hDEADBEEF. Required: `mem_req` high for 3 cycles; WB has `f_LW` = 1, `f_wen` = 1, `f_rd` = 7, `flags_we` = 0.
3. **Store.** Stimulus: instr_store, rs2 = 9; `mem_ack` on the 1st cycle. Required: `f_SW` = 1, `f_rs2` = 9, `mem_req` = 1; no `f_wen`; back in IDLE the next cycle.
4. **Illegal rounding and load+store.** Stimulus: rm = 101; then csr_frm = 110 with rm = 111; then instr_load and instr_store both set. Required: each produces an `err` pulse, no EXEC/LOAD/STORE entry, no write.
5. **Timeout.** Stimulus: TIMEOUT_CYCLES = 16, `f_ready` never asserted. Required: `err` pulse after 16 EXEC cycles, IDLE, no `f_wen`; a `f_ready` pulse arriving later is ignored.
6. **Reset mid-operation.** Stimulus: `n_rst` = 0 for one edge in EXEC cycle 2, then `f_ready`. Required: state IDLE, `instr_ready` = 1, `f_wen` and `err` never asserted.

Source files
------------

// File: rtl/fpu_types_pkg.sv
// Shared types and constants for the FP issue path: controller state encoding,
// rounding-mode encodings and fcsr flag bit positions.
package fpu_types_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_EXEC  = 3'd1,
      ST_LOAD  = 3'd2,
      ST_STORE = 3'd3,
      ST_WB    = 3'd4
   } state_t;

   localparam logic [2:0] RM_RNE = 3'b000;
   localparam logic [2:0] RM_RTZ = 3'b001;
   localparam logic [2:0] RM_RDN = 3'b010;
   localparam logic [2:0] RM_RUP = 3'b011;
   localparam logic [2:0] RM_RMM = 3'b100;
   localparam logic [2:0] RM_DYN = 3'b111;

   localparam int FLAG_NV = 4;
   localparam int FLAG_DZ = 3;
   localparam int FLAG_OF = 2;
   localparam int FLAG_UF = 1;
   localparam int FLAG_NX = 0;

   // Encodings 101 and 110 are reserved and trap as illegal instructions.
   function automatic logic rm_is_legal(input logic [2:0] rm);
      return (rm != 3'b101) && (rm != 3'b110);
   endfunction

endpackage

// File: rtl/fpu_rm_resolve.sv
// Combinational rounding-mode resolution: picks the fcsr mode for dynamic
// encodings and flags reserved results as illegal.
import fpu_types_pkg::*;

module fpu_rm_resolve (
   input  logic [2:0] instr_rm,
   input  logic [2:0] csr_frm,
   output logic [2:0] frm,
   output logic       legal
);

   // Resolve dynamic rounding then check the effective mode.
   always_comb begin
      frm   = 3'b000;
      legal = 1'b0;
      if (instr_rm == RM_DYN) begin
         frm = csr_frm;
      end else begin
         frm = instr_rm;
      end
      legal = rm_is_legal(frm);
   end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Initiator-side FP issue controller: accepts decoded FP instructions, drives the
// FPU, sequences FLW/FSW over a req/ack memory port and performs register write-back.
import fpu_types_pkg::*;

module fpu_issue_ctrl #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 5
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [6:0]  instr_funct7,
   input  logic [4:0]  instr_rs1,
   input  logic [4:0]  instr_rs2,
   input  logic [4:0]  instr_rd,
   input  logic [2:0]  instr_rm,
   input  logic        instr_load,
   input  logic        instr_store,
   input  logic [2:0]  csr_frm,
   input  logic [31:0] FPU_out,
   input  logic [4:0]  flags,
   input  logic        f_ready,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        mem_req,
   output logic [4:0]  f_rs1,
   output logic [4:0]  f_rs2,
   output logic [4:0]  f_rd,
   output logic [6:0]  funct_7,
   output logic [2:0]  frm,
   output logic        f_LW,
   output logic        f_SW,
   output logic [31:0] f_w_data,
   output logic        f_wen,
   output logic [4:0]  f_flags,
   output logic        flags_we,
   output logic        err
);

   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state_r;
   state_t           state_s;
   logic             accept_s;
   logic             err_s;
   logic [CNT_W-1:0] cnt_r;
   logic             is_load_r;
   logic [2:0]       rm_frm_s;
   logic             rm_legal_s;

   fpu_rm_resolve u_rm_resolve (
      .instr_rm (instr_rm),
      .csr_frm  (csr_frm),
      .frm      (rm_frm_s),
      .legal    (rm_legal_s)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode, acceptance and error detection.
   always_comb begin
      state_s  = state_r;
      accept_s = 1'b0;
      err_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (instr_valid && instr_ready) begin
               accept_s = 1'b1;
               if (instr_load && instr_store) begin
                  err_s = 1'b1;
               end else if (instr_load) begin
                  state_s = ST_LOAD;
               end else if (instr_store) begin
                  state_s = ST_STORE;
               end else if (!rm_legal_s) begin
                  err_s = 1'b1;
               end else begin
                  state_s = ST_EXEC;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_EXEC: begin
            // A result arriving on the last allowed cycle still completes.
            if (f_ready) begin
               state_s = ST_WB;
            end else if (cnt_r == TMO_LAST) begin
               err_s   = 1'b1;
               state_s = ST_IDLE;
            end else begin
               state_s = ST_EXEC;
            end
         end
         ST_LOAD: begin
            if (mem_ack) begin
               state_s = ST_WB;
            end else begin
               state_s = ST_LOAD;
            end
         end
         ST_STORE: begin
            if (mem_ack) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_STORE;
            end
         end
         ST_WB:   state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // Registered outputs and datapath latches; strobes follow the next state so
   // they line up with the cycle spent in that state.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         instr_ready <= 1'b1;
         mem_req     <= 1'b0;
         f_rs1       <= 5'd0;
         f_rs2       <= 5'd0;
         f_rd        <= 5'd0;
         funct_7     <= 7'd0;
         frm         <= 3'd0;
         f_LW        <= 1'b0;
         f_SW        <= 1'b0;
         f_w_data    <= 32'd0;
         f_wen       <= 1'b0;
         f_flags     <= 5'd0;
         flags_we    <= 1'b0;
         err         <= 1'b0;
         cnt_r       <= '0;
         is_load_r   <= 1'b0;
      end else begin
         instr_ready <= (state_s == ST_IDLE);
         mem_req     <= (state_s == ST_LOAD) || (state_s == ST_STORE);
         f_SW        <= (state_s == ST_STORE);
         f_wen       <= (state_s == ST_WB);
         f_LW        <= (state_s == ST_WB) && is_load_r;
         flags_we    <= (state_s == ST_WB) && !is_load_r;
         err         <= err_s;
         if (state_r == ST_EXEC) begin
            cnt_r <= cnt_r + CNT_W'(1);
         end else begin
            cnt_r <= '0;
         end
         if (accept_s) begin
            f_rs1     <= instr_rs1;
            f_rs2     <= instr_rs2;
            f_rd      <= instr_rd;
            is_load_r <= instr_load;
         end
         if (accept_s && (state_s == ST_EXEC)) begin
            funct_7 <= instr_funct7;
            frm     <= rm_frm_s;
         end
         if ((state_r == ST_EXEC) && f_ready) begin
            f_w_data <= FPU_out;
            f_flags  <= flags;
         end
         if ((state_r == ST_LOAD) && mem_ack) begin
            f_w_data <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed self-checking bench for fpu_issue_ctrl with a write-back scoreboard.
module tb_fpu_issue_ctrl;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        instr_valid, instr_ready;
   logic [6:0]  instr_funct7;
   logic [4:0]  instr_rs1, instr_rs2, instr_rd;
   logic [2:0]  instr_rm, csr_frm;
   logic        instr_load, instr_store;
   logic [31:0] FPU_out, mem_rdata, f_w_data;
   logic [4:0]  flags, f_rs1, f_rs2, f_rd, f_flags;
   logic        f_ready, mem_ack, mem_req;
   logic [6:0]  funct_7;
   logic [2:0]  frm;
   logic        f_LW, f_SW, f_wen, flags_we, err;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
      logic [4:0]  flg;
      logic        ld;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   wen_cnt = 0;
   int   err_cnt = 0;

   always #5 clk = ~clk;

   fpu_issue_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
      .clk(clk), .n_rst(n_rst),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_funct7(instr_funct7), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
      .instr_rd(instr_rd), .instr_rm(instr_rm), .instr_load(instr_load),
      .instr_store(instr_store), .csr_frm(csr_frm),
      .FPU_out(FPU_out), .flags(flags), .f_ready(f_ready),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_req(mem_req),
      .f_rs1(f_rs1), .f_rs2(f_rs2), .f_rd(f_rd), .funct_7(funct_7), .frm(frm),
      .f_LW(f_LW), .f_SW(f_SW), .f_w_data(f_w_data), .f_wen(f_wen),
      .f_flags(f_flags), .flags_we(flags_we), .err(err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [6:0] f7, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [2:0] rm, input logic ld, input logic st);
      instr_funct7 = f7; instr_rs1 = rs1; instr_rs2 = rs2; instr_rd = rd;
      instr_rm = rm; instr_load = ld; instr_store = st; instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
   endtask

   // Write-back scoreboard and pulse counters, sampled mid-cycle.
   always @(negedge clk) begin
      if (err === 1'b1) err_cnt++;
      if (f_wen === 1'b1) begin
         wen_cnt++;
         if (sb.size() == 0) begin
            chk("sb_unexpected_wen", {27'd0, f_rd}, 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_rd",   {27'd0, f_rd}, {27'd0, e.rd});
            chk("sb_data", f_w_data, e.data);
            chk("sb_lw",   {31'd0, f_LW}, {31'd0, e.ld});
            chk("sb_fwe",  {31'd0, flags_we}, {31'd0, ~e.ld});
            if (!e.ld) chk("sb_flags", {27'd0, f_flags}, {27'd0, e.flg});
         end
      end
   end

   initial begin
      int w0, e0;
      n_rst = 1'b0; instr_valid = 1'b0; instr_funct7 = 7'd0; instr_rs1 = 5'd0;
      instr_rs2 = 5'd0; instr_rd = 5'd0; instr_rm = 3'd0; instr_load = 1'b0;
      instr_store = 1'b0; csr_frm = 3'd0; FPU_out = 32'd0; flags = 5'd0;
      f_ready = 1'b0; mem_rdata = 32'd0; mem_ack = 1'b0;
      tick(); tick();
      n_rst = 1'b1;
      chk("rst_ready", {31'd0, instr_ready}, 32'd1);
      chk("rst_wen",   {31'd0, f_wen}, 32'd0);
      chk("rst_err",   {31'd0, err}, 32'd0);
      chk("rst_req",   {31'd0, mem_req}, 32'd0);
      chk("rst_rs1",   {27'd0, f_rs1}, 32'd0);

      // 1: dynamic rounding, result after three cycles
      csr_frm = 3'b001;
      issue(7'h00, 5'd1, 5'd2, 5'd3, 3'b111, 1'b0, 1'b0);
      sb.push_back('{rd: 5'd3, data: 32'h4040_0000, flg: 5'b00001, ld: 1'b0});
      chk("t1_frm",   {29'd0, frm}, 32'd1);
      chk("t1_busy",  {31'd0, instr_ready}, 32'd0);
      chk("t1_rs1",   {27'd0, f_rs1}, 32'd1);
      chk("t1_rs2",   {27'd0, f_rs2}, 32'd2);
      tick(); tick();
      chk("t1_frm_hold", {29'd0, frm}, 32'd1);
      tick();
      f_ready = 1'b1; FPU_out = 32'h4040_0000; flags = 5'b00001;
      tick();
      f_ready = 1'b0; FPU_out = 32'd0; flags = 5'd0;
      chk("t1_wb_wen",  {31'd0, f_wen}, 32'd1);
      chk("t1_wb_data", f_w_data, 32'h4040_0000);
      chk("t1_wb_rdy",  {31'd0, instr_ready}, 32'd0);
      tick();
      chk("t1_ready5",  {31'd0, instr_ready}, 32'd1);
      chk("t1_wen_off", {31'd0, f_wen}, 32'd0);

      // 2: load with two wait cycles
      issue(7'h00, 5'd0, 5'd0, 5'd7, 3'b000, 1'b1, 1'b0);
      sb.push_back('{rd: 5'd7, data: 32'hDEAD_BEEF, flg: 5'd0, ld: 1'b1});
      chk("t2_req1", {31'd0, mem_req}, 32'd1);
      tick();
      chk("t2_req2", {31'd0, mem_req}, 32'd1);
      tick();
      chk("t2_req3", {31'd0, mem_req}, 32'd1);
      mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      tick();
      mem_ack = 1'b0; mem_rdata = 32'd0;
      chk("t2_req_off", {31'd0, mem_req}, 32'd0);
      chk("t2_lw",      {31'd0, f_LW}, 32'd1);
      chk("t2_rd",      {27'd0, f_rd}, 32'd7);
      tick();
      chk("t2_ready", {31'd0, instr_ready}, 32'd1);

      // 3: store acknowledged on its first cycle
      w0 = wen_cnt;
      issue(7'h00, 5'd0, 5'd9, 5'd0, 3'b000, 1'b0, 1'b1);
      chk("t3_sw",  {31'd0, f_SW}, 32'd1);
      chk("t3_rs2", {27'd0, f_rs2}, 32'd9);
      chk("t3_req", {31'd0, mem_req}, 32'd1);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("t3_ready", {31'd0, instr_ready}, 32'd1);
      chk("t3_sw_off", {31'd0, f_SW}, 32'd0);
      tick();
      chk("t3_nowen", wen_cnt, w0);

      // 4: illegal rounding modes and load+store
      w0 = wen_cnt; e0 = err_cnt;
      issue(7'h00, 5'd1, 5'd1, 5'd1, 3'b101, 1'b0, 1'b0);
      chk("t4a_err",   {31'd0, err}, 32'd1);
      chk("t4a_ready", {31'd0, instr_ready}, 32'd1);
      chk("t4a_frm",   {29'd0, frm}, 32'd1);
      tick();
      chk("t4a_pulse", {31'd0, err}, 32'd0);
      csr_frm = 3'b110;
      issue(7'h00, 5'd1, 5'd1, 5'd1, 3'b111, 1'b0, 1'b0);
      chk("t4b_err",   {31'd0, err}, 32'd1);
      chk("t4b_ready", {31'd0, instr_ready}, 32'd1);
      tick();
      csr_frm = 3'b000;
      issue(7'h00, 5'd1, 5'd1, 5'd1, 3'b000, 1'b1, 1'b1);
      chk("t4c_err", {31'd0, err}, 32'd1);
      chk("t4c_req", {31'd0, mem_req}, 32'd0);
      chk("t4c_sw",  {31'd0, f_SW}, 32'd0);
      tick();
      chk("t4_errs", err_cnt - e0, 32'd3);
      chk("t4_nowen", wen_cnt, w0);

      // 5: timeout after 16 EXEC cycles, late f_ready ignored
      w0 = wen_cnt; e0 = err_cnt;
      issue(7'h01, 5'd4, 5'd5, 5'd6, 3'b000, 1'b0, 1'b0);
      for (int i = 0; i < 15; i++) tick();
      chk("t5_still_exec", {31'd0, instr_ready}, 32'd0);
      chk("t5_no_err_yet", {31'd0, err}, 32'd0);
      tick();
      chk("t5_err",   {31'd0, err}, 32'd1);
      chk("t5_ready", {31'd0, instr_ready}, 32'd1);
      f_ready = 1'b1;
      tick();
      f_ready = 1'b0;
      chk("t5_late_wen", {31'd0, f_wen}, 32'd0);
      chk("t5_idle",     {31'd0, instr_ready}, 32'd1);
      tick();
      chk("t5_nowen", wen_cnt, w0);
      chk("t5_errs",  err_cnt - e0, 32'd1);

      // 6: reset in EXEC cycle 2
      w0 = wen_cnt; e0 = err_cnt;
      issue(7'h02, 5'd8, 5'd8, 5'd8, 3'b010, 1'b0, 1'b0);
      tick();
      n_rst = 1'b0;
      tick();
      n_rst = 1'b1;
      chk("t6_ready", {31'd0, instr_ready}, 32'd1);
      chk("t6_rs1",   {27'd0, f_rs1}, 32'd0);
      chk("t6_frm",   {29'd0, frm}, 32'd0);
      f_ready = 1'b1; FPU_out = 32'h1234_5678;
      tick();
      f_ready = 1'b0; FPU_out = 32'd0;
      tick();
      chk("t6_nowen", wen_cnt, w0);
      chk("t6_noerr", err_cnt, e0);

      // recovery: one-cycle op after reset
      issue(7'h03, 5'd10, 5'd11, 5'd12, 3'b100, 1'b0, 1'b0);
      sb.push_back('{rd: 5'd12, data: 32'hCAFE_0001, flg: 5'b10000, ld: 1'b0});
      chk("t7_frm", {29'd0, frm}, 32'd4);
      f_ready = 1'b1; FPU_out = 32'hCAFE_0001; flags = 5'b10000;
      tick();
      f_ready = 1'b0; FPU_out = 32'd0; flags = 5'd0;
      tick(); tick();

      chk("sb_empty",  sb.size(), 32'd0);
      chk("total_wen", wen_cnt, 32'd3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
